// File: rtl/m68k_irq_ctrl.sv
// 68000-style interrupt controller: edge-latched sources, priority
// encoded onto IPL, cleared by software or by CPU acknowledge cycles.
module m68k_irq_ctrl #(
  parameter int NUM_SRC = 4,
  parameter logic [3*NUM_SRC-1:0] SRC_LEVEL = 12'b000_000_101_110,
  parameter logic [NUM_SRC-1:0] SRC_RISE = '1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] src,
  input  logic [NUM_SRC-1:0] mask,
  input  logic [NUM_SRC-1:0] clr,
  input  logic               iack,
  input  logic [2:0]         ack_level,
  output logic [2:0]         ipl_n,
  output logic [NUM_SRC-1:0] pending,
  output logic [NUM_SRC-1:0] ack_src
);

  logic [NUM_SRC-1:0] src_prev;
  logic               iack_prev;
  logic [NUM_SRC-1:0] edge_hit;
  logic [NUM_SRC-1:0] en;
  logic [NUM_SRC-1:0] ack_sel;
  logic [NUM_SRC-1:0] pend_nxt;
  logic               ack_rise;
  logic               found;
  logic [2:0]         lvl;

  always_comb begin
    en       = '0;
    ack_sel  = '0;
    found    = 1'b0;
    lvl      = 3'd0;
    ack_rise = iack & ~iack_prev;
    edge_hit = (src & ~src_prev & SRC_RISE)
             | (~src & src_prev & ~SRC_RISE);
    for (int i = 0; i < NUM_SRC; i++) begin
      en[i] = |SRC_LEVEL[3*i +: 3];
      // only the lowest-index match at the acked level is serviced
      if (!found && ack_rise && pending[i] && !mask[i]
          && SRC_LEVEL[3*i +: 3] == ack_level) begin
        ack_sel[i] = 1'b1;
        found      = 1'b1;
      end
      if (pending[i] && !mask[i] && SRC_LEVEL[3*i +: 3] > lvl)
        lvl = SRC_LEVEL[3*i +: 3];
    end
    // a fresh edge wins over any clear in the same cycle
    pend_nxt = (pending & ~clr & ~ack_sel) | (edge_hit & en);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      src_prev  <= ~SRC_RISE;
      iack_prev <= 1'b0;
      pending   <= '0;
      ack_src   <= '0;
      ipl_n     <= 3'b111;
    end else begin
      src_prev  <= src;
      iack_prev <= iack;
      pending   <= pend_nxt;
      ack_src   <= ack_sel;
      ipl_n     <= ~lvl;
    end
  end

endmodule
